// File: rtl/decr_cnt.sv
// decr_cnt -- loadable down-counter with a valid/ready load handshake.
//
// A load of N (N != 0) starts a count that steps down once per enabled
// clock edge and raises done_o for one cycle when the count reaches zero.
// A load of 0 finishes immediately: done_o pulses on the following cycle.
// abort_i cancels a running count silently.
//
// Optional build macro:
//   DECR_CNT_AUTO_RELOAD_EN -- the counter restarts from the last nonzero
//   loaded value instead of stopping at zero.
//   - It leaves RUN only through abort_i or reset.
//   - done_o then pulses every N+1 enabled edges.

module decr_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             en_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q,  done_d;
    logic             load_fire;
`ifdef DECR_CNT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Handshake completes when a request meets an idle, out-of-reset block.
    assign load_fire = load_valid_i && load_ready_o;

    // Next-state, next-count and done-pulse decision for the coming edge.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef DECR_CNT_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                // en_i and abort_i have no meaning here; only a load matters.
                if (load_fire) begin
                    count_d = load_data_i;
                    if (load_data_i != '0) begin
                        state_d = RUN;
`ifdef DECR_CNT_AUTO_RELOAD_EN
                        reload_d = load_data_i;
`endif
                    end else begin
                        // Zero-length count: report completion at once.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    // Cancel wins over enable and never produces a done pulse.
                    state_d = IDLE;
                    count_d = '0;
                end else if (en_i) begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifndef DECR_CNT_AUTO_RELOAD_EN
                            state_d = IDLE;
`endif
                        end
                    end
`ifdef DECR_CNT_AUTO_RELOAD_EN
                    else begin
                        // Zero was shown for one enabled cycle; start again.
                        count_d = reload_q;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, count and done registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef DECR_CNT_AUTO_RELOAD_EN
    // Reload value register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the reload value is reset as well, so a restart can never
        // pick up a stale value after reset.
        if (rst_i) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // Output decode.
    assign load_ready_o = (state_q == IDLE) && !rst_i;
    assign busy_o       = (state_q == RUN);
    assign count_o      = count_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_decr_cnt.sv
// tb_decr_cnt -- self-checking bench for decr_cnt (WIDTH = 4).
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// there too, well away from the active edge. Compile with
// DECR_CNT_AUTO_RELOAD_EN defined to exercise the auto-reload mode.

module tb_decr_cnt;

    localparam int WIDTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             load_valid_i = 1'b0;
    logic             load_ready_o;
    logic [WIDTH-1:0] load_data_i = '0;
    logic             en_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;

`ifdef DECR_CNT_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    decr_cnt #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i),
        .en_i         (en_i),
        .abort_i      (abort_i),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic lv, input logic [WIDTH-1:0] d,
                          input logic en, input logic ab);
        load_valid_i = lv;
        load_data_i  = d;
        en_i         = en;
        abort_i      = ab;
    endtask

    // Bring the block back to IDLE with no pending done pulse.
    task automatic go_idle();
        set_in(1'b0, '0, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, '0, 1'b0, 1'b0);
        cycle();
    endtask

    task automatic test_reset();
        #2;
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        total++; if (load_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", load_ready_o); end
        cycle();
        cycle();
        rst_i = 1'b0;
        #1;
        total++; if (load_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", load_ready_o); end
    endtask

    task automatic test_load5();
        logic exp_busy;
        set_in(1'b1, 4'd5, 1'b1, 1'b0);
        cycle();
        total++; if (count_o !== 4'd5) begin bad++; $display("FAIL load5_first: got %0d want 5", count_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL load5_busy: got %b want 1", busy_o); end
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int k = 4; k >= 0; k--) begin
            cycle();
            exp_busy = AUTO ? 1'b1 : (k != 0);
            total++; if (count_o !== 4'(k)) begin bad++; $display("FAIL load5_count: got %0d want %0d", count_o, k); end
            total++; if (done_o !== (k == 0)) begin bad++; $display("FAIL load5_done: at %0d got %b want %b", k, done_o, (k == 0)); end
            total++; if (load_ready_o !== !exp_busy) begin bad++; $display("FAIL load5_ready: at %0d got %b want %b", k, load_ready_o, !exp_busy); end
        end
        go_idle();
    endtask

    task automatic test_load_zero();
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b0, 1'b0);
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy_o); end
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL zero_count: got %0d want 0", count_o); end
        cycle();
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_done_clear: got %b want 0", done_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_busy_after: got %b want 0", busy_o); end
    endtask

    task automatic test_en_pattern();
        logic [WIDTH-1:0] exp_cnt [5];
        logic             pat     [5];
        int               dones;
        exp_cnt = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dones   = 0;
        set_in(1'b1, 4'd3, 1'b0, 1'b0);
        cycle();
        total++; if (count_o !== 4'd3) begin bad++; $display("FAIL pat_load: got %0d want 3", count_o); end
        for (int i = 0; i < 5; i++) begin
            // A competing load request stays up for the whole run.
            set_in(1'b1, 4'd9, pat[i], 1'b0);
            total++; if (load_ready_o !== 1'b0) begin bad++; $display("FAIL pat_ready_in_run: step %0d got %b want 0", i, load_ready_o); end
            cycle();
            if (done_o === 1'b1) dones++;
            total++; if (count_o !== exp_cnt[i]) begin bad++; $display("FAIL pat_count: step %0d got %0d want %0d", i, count_o, exp_cnt[i]); end
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        total++; if (dones != 1) begin bad++; $display("FAIL pat_done_count: got %0d want 1", dones); end
        go_idle();
    endtask

    task automatic test_abort();
        bit reached;
        int dones;
        reached = 1'b0;
        set_in(1'b1, 4'd15, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (count_o == 4'd2) begin
                reached = 1'b1;
                break;
            end
            cycle();
        end
        total++; if (!reached) begin bad++; $display("FAIL abort_reach2: timeout, count %0d want 2", count_o); end
        set_in(1'b0, '0, 1'b1, 1'b1);
        cycle();
        set_in(1'b0, '0, 1'b0, 1'b0);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL abort_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done_o); end
        total++; if (load_ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", load_ready_o); end
        cycle();
        // A full-range run of 15 enabled edges.
        dones = 0;
        set_in(1'b1, 4'd15, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (done_o === 1'b1) dones++;
            total++; if (count_o !== 4'(14 - i)) begin bad++; $display("FAIL full_count: step %0d got %0d want %0d", i, count_o, 14 - i); end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", dones); end
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL full_done_last: got %b want 1", done_o); end
        total++; if (busy_o !== AUTO) begin bad++; $display("FAIL full_busy_end: got %b want %b", busy_o, AUTO); end
        go_idle();
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 4'd7, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b1, 1'b0);
        cycle();
        cycle();
        cycle();
        total++; if (count_o !== 4'd4) begin bad++; $display("FAIL arst_pre_count: got %0d want 4", count_o); end
        #1 rst_i = 1'b1;
        #1;
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL arst_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL arst_done: got %b want 0", done_o); end
        total++; if (load_ready_o !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b want 0", load_ready_o); end
        set_in(1'b0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        rst_i = 1'b0;
        #1;
        total++; if (load_ready_o !== 1'b1) begin bad++; $display("FAIL arst_release_ready: got %b want 1", load_ready_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL arst_release_done: got %b want 0", done_o); end
        set_in(1'b1, 4'd1, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b1, 1'b0);
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL arst_load1: got %0d want 1", count_o); end
        cycle();
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL arst_end_count: got %0d want 0", count_o); end
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL arst_end_done: got %b want 1", done_o); end
        go_idle();
    endtask

`ifdef DECR_CNT_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [WIDTH-1:0] exp_cnt [8];
        exp_cnt = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        set_in(1'b1, 4'd2, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            total++; if (count_o !== exp_cnt[i]) begin bad++; $display("FAIL reload_count: step %0d got %0d want %0d", i, count_o, exp_cnt[i]); end
            total++; if (done_o !== (exp_cnt[i] == 4'd0)) begin bad++; $display("FAIL reload_done: step %0d got %b", i, done_o); end
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL reload_busy: step %0d got %b want 1", i, busy_o); end
        end
        set_in(1'b0, '0, 1'b1, 1'b1);
        cycle();
        set_in(1'b0, '0, 1'b0, 1'b0);
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reload_abort_count: got %0d want 0", count_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reload_abort_busy: got %b want 0", busy_o); end
        cycle();
    endtask
`endif

    // Random traffic against a behavioural model of the counter.
    task automatic test_random();
        int   m_count;
        int   m_reload;
        bit   m_run;
        bit   m_done;
        logic lv, en, ab;
        logic [WIDTH-1:0] d;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        m_count = 0; m_reload = 0; m_run = 1'b0; m_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            lv = ($urandom % 3) == 0;
            d  = ($urandom % 2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            en = ($urandom % 4) != 0;
            ab = ($urandom % 16) == 0;
            set_in(lv, d, en, ab);
            // Model update for this edge.
            m_done = 1'b0;
            if (!m_run) begin
                if (lv) begin
                    m_count = int'(d);
                    if (d != 0) begin
                        m_run = 1'b1;
                        m_reload = int'(d);
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end else if (ab) begin
                m_count = 0;
                m_run = 1'b0;
            end else if (en) begin
                if (m_count == 0) begin
                    m_count = m_reload;
                end else begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_done = 1'b1;
                        if (!AUTO) m_run = 1'b0;
                    end
                end
            end
            cycle();
            total++; if (count_o !== 4'(m_count)) begin bad++; $display("FAIL rand_count: cycle %0d got %0d want %0d", n, count_o, m_count); end
            total++; if (done_o !== m_done) begin bad++; $display("FAIL rand_done: cycle %0d got %b want %b", n, done_o, m_done); end
            total++; if (busy_o !== m_run) begin bad++; $display("FAIL rand_busy: cycle %0d got %b want %b", n, busy_o, m_run); end
            total++; if (load_ready_o !== !m_run) begin bad++; $display("FAIL rand_ready: cycle %0d got %b want %b", n, load_ready_o, !m_run); end
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load5();
        test_load_zero();
        test_en_pattern();
        test_abort();
        test_async_reset();
`ifdef DECR_CNT_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
